// File: rtl/rc4_ksa_engine.sv
// rc4_ksa_engine: RC4 key scheduling (identity fill and key-driven shuffle) over an external single-port S-RAM.
module rc4_ksa_engine #(
    parameter int AW        = 8,
    parameter int KEY_BYTES = 3,
    parameter int RD_LAT    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [8*KEY_BYTES-1:0] secret,
    input  logic [AW-1:0]          data_in,
    output logic [AW-1:0]          addr_out,
    output logic [AW-1:0]          data_out,
    output logic                   mem_write,
    output logic                   busy,
    output logic                   finish
);
    localparam int KW = KEY_BYTES > 1 ? $clog2(KEY_BYTES) : 1;
    localparam int CW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
    localparam logic [2:0] IDLE = 3'd0, INIT = 3'd1, RD_I = 3'd2, CALC_J = 3'd3,
                           RD_J = 3'd4, WR_J = 3'd5, WR_I = 3'd6, DONE = 3'd7;

    logic [2:0]    state;
    logic [AW-1:0] i, j, si, sj;
    logic [KW-1:0] k;
    logic [CW-1:0] cnt;
    logic [1:0]    mode_r;
    logic [7:0]    key_arr [KEY_BYTES];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            si     <= '0;
            sj     <= '0;
            cnt    <= '0;
            mode_r <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    for (int n = 0; n < KEY_BYTES; n++)
                        key_arr[n] <= secret[8*(KEY_BYTES-1-n) +: 8];
                    mode_r <= mode;
                    i      <= '0;
                    j      <= '0;
                    k      <= '0;
                    cnt    <= '0;
                    state  <= (mode == 2'b10) ? RD_I : INIT;
                end
                INIT: begin
                    i <= i + 1'b1;
                    if (i == '1) state <= (mode_r == 2'b01) ? DONE : RD_I;
                end
                // hold the address RD_LAT cycles, capture on the last edge
                RD_I: if (cnt == CW'(RD_LAT-1)) begin
                    si    <= data_in;
                    cnt   <= '0;
                    state <= CALC_J;
                end else cnt <= cnt + 1'b1;
                CALC_J: begin
                    j     <= j + si + key_arr[k][AW-1:0];
                    state <= RD_J;
                end
                RD_J: if (cnt == CW'(RD_LAT-1)) begin
                    sj    <= data_in;
                    cnt   <= '0;
                    state <= WR_J;
                end else cnt <= cnt + 1'b1;
                WR_J: state <= WR_I;
                WR_I: begin
                    i     <= i + 1'b1;
                    k     <= (k == KW'(KEY_BYTES-1)) ? '0 : k + 1'b1;
                    state <= (i == '1) ? DONE : RD_I;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign addr_out  = (state == INIT || state == RD_I || state == WR_I) ? i :
                       (state == RD_J || state == WR_J) ? j : '0;
    assign data_out  = (state == INIT) ? i : (state == WR_J) ? si : (state == WR_I) ? sj : '0;
    assign mem_write = (state == INIT) || (state == WR_J) || (state == WR_I);
    assign busy      = (state != IDLE);
    assign finish    = (state == DONE);
endmodule
